// File: rtl/shift_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// shift_sequencer_pkg
//   Shared definitions for the shift sequencer slice: default datapath sizes,
//   the FSM state encoding and the registered output bundle with its decoder.
//   No ports (package).
// ----------------------------------------------------------------------------
package shift_sequencer_pkg;

    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_AMT_W = $clog2(SEQ_WIDTH);

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_SHIFT = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    // Control outputs that are a pure function of the FSM state.
    typedef struct packed {
        logic reqReady;
        logic srLoad;
        logic srShiftEn;
        logic rspValid;
        logic busy;
    } seq_outs_t;

    // Decoding the next state lets the outputs be registered alongside it,
    // so every control output comes straight from a flop.
    function automatic seq_outs_t decodeOutputs(input seq_state_e s);
        seq_outs_t o;
        o           = '0;
        o.reqReady  = (s == SEQ_IDLE);
        o.srLoad    = (s == SEQ_LOAD);
        o.srShiftEn = (s == SEQ_SHIFT);
        o.rspValid  = (s == SEQ_DONE);
        o.busy      = (s != SEQ_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// ----------------------------------------------------------------------------
// shift_sequencer_if
//   Request/response channels between the shift-operation issuer and the
//   sequencer.
//   req_valid/req_ready/req_data/req_amt : job offer (word + shift count)
//   rsp_valid/rsp_ready/rsp_data         : shifted result
//   master modport = issuer, slave modport = sequencer.
// ----------------------------------------------------------------------------
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int AMT_W = SEQ_AMT_W
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_data, req_amt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_amt, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_register.sv
// ----------------------------------------------------------------------------
// shift_register
//   Datapath register driven by the sequencer: parallel load, or a one-bit
//   left shift with zero fill per enabled cycle.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : parallel load strobe
//   data_i     : parallel load value
//   shift_en_i : shift left by one bit
//   q_o        : register contents
// ----------------------------------------------------------------------------
module shift_register
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Load wins over shift if both are ever asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= data_i;
        end else if (shift_en_i) begin
            q_q <= {q_q[WIDTH-2:0], 1'b0};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_seq_counter.sv
// ----------------------------------------------------------------------------
// shift_seq_counter
//   Loadable down-counter holding the number of shifts still to issue.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture load_val_i
//   load_val_i   : shift count of the accepted job
//   dec_i        : decrement by one
//   is_one_o     : count equals 1 (last shift cycle)
//   is_zero_o    : count equals 0 (no shifts required)
// ----------------------------------------------------------------------------
module shift_seq_counter
    import shift_sequencer_pkg::*;
#(
    parameter int AMT_W = SEQ_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [AMT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [AMT_W-1:0] cnt_q;

    // Load has priority; the sequencer never loads and decrements together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - AMT_W'(1);
        end
    end

    assign is_one_o  = (cnt_q == AMT_W'(1));
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// ----------------------------------------------------------------------------
// shift_sequencer
//   Sequences the shift register: accepts a job (word + count), loads the
//   word, issues exactly count single-bit shift enables, then presents the
//   register contents as the result until the consumer takes it.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : request/response channels (shift_sequencer_if.slave)
//   busy        : a job is in progress (state is not IDLE)
//   sr_load     : one-cycle parallel load strobe to the shift register
//   sr_data_in  : load value for the shift register
//   sr_shift_en : shift register shifts left one bit this cycle
//   sr_q        : shift register contents
//   Optional macro SHIFT_SEQ_ABORT_EN adds:
//   abort       : cancel the job while in LOAD or SHIFT
//   abort_ack   : one-cycle acknowledge of an accepted abort
// ----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int AMT_W = SEQ_AMT_W
) (
    input  logic                clk,
    input  logic                reset,
    shift_sequencer_if.slave    bus,
    output logic                busy,
    output logic                sr_load,
    output logic [WIDTH-1:0]    sr_data_in,
    output logic                sr_shift_en,
    input  logic [WIDTH-1:0]    sr_q
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic                abort,
    output logic                abort_ack
`endif
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    seq_outs_t        outs_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             cntIsOne;
    logic             cntIsZero;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abortAck_q;
    logic             abortAck_d;
`endif

    assign accept = (state_q == SEQ_IDLE) && bus.req_valid;

    shift_seq_counter #(
        .AMT_W (AMT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (bus.req_amt),
        .dec_i      (state_q == SEQ_SHIFT),
        .is_one_o   (cntIsOne),
        .is_zero_o  (cntIsZero)
    );

    // Next-state logic. A zero count skips SHIFT entirely; the last shift
    // cycle is the one where the counter still reads 1. An abort during the
    // active phases overrides the normal transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:  if (bus.req_valid) state_d = SEQ_LOAD;
            SEQ_LOAD:  state_d = cntIsZero ? SEQ_DONE : SEQ_SHIFT;
            SEQ_SHIFT: if (cntIsOne) state_d = SEQ_DONE;
            SEQ_DONE:  if (bus.rsp_ready) state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
`ifdef SHIFT_SEQ_ABORT_EN
        abortAck_d = abort && ((state_q == SEQ_LOAD) || (state_q == SEQ_SHIFT));
        if (abortAck_d) state_d = SEQ_IDLE;
`endif
    end

    // State, registered control outputs and the captured job word. Outputs
    // are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            outs_q     <= decodeOutputs(SEQ_IDLE);
            data_q     <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
            abortAck_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            outs_q  <= decodeOutputs(state_d);
            if (accept) data_q <= bus.req_data;
`ifdef SHIFT_SEQ_ABORT_EN
            abortAck_q <= abortAck_d;
`endif
        end
    end

    // The result is only driven while valid so every output idles at zero.
    assign bus.req_ready = outs_q.reqReady;
    assign bus.rsp_valid = outs_q.rspValid;
    assign bus.rsp_data  = outs_q.rspValid ? sr_q : '0;
    assign busy          = outs_q.busy;
    assign sr_load       = outs_q.srLoad;
    assign sr_shift_en   = outs_q.srShiftEn;
    assign sr_data_in    = data_q;
`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_ack     = abortAck_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer driving a shift_register.
//   Directed jobs plus randomized jobs checked against an arithmetic model.
//   Abort scenarios are included when SHIFT_SEQ_ABORT_EN is defined.
// ----------------------------------------------------------------------------
module tb_shift_sequencer;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       sr_load;
    logic [7:0] sr_data_in;
    logic       sr_shift_en;
    logic [7:0] sr_q;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort;
    logic       abort_ack;
`endif

    int checks;
    int passes;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shift_sequencer #(
        .WIDTH (8),
        .AMT_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .sr_load     (sr_load),
        .sr_data_in  (sr_data_in),
        .sr_shift_en (sr_shift_en),
        .sr_q        (sr_q)
`ifdef SHIFT_SEQ_ABORT_EN
        ,
        .abort       (abort),
        .abort_ack   (abort_ack)
`endif
    );

    shift_register #(
        .WIDTH (8)
    ) u_sr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (sr_load),
        .data_i     (sr_data_in),
        .shift_en_i (sr_shift_en),
        .q_o        (sr_q)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: the word multiplied by 2^amt, wrapped to 8 bits.
    function automatic logic [7:0] refShift(input int data, input int amt);
        return 8'((data * (2 ** amt)) % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " req_ready"},   32'(bus.req_ready), 32'd1);
        checkOutput({tag, " busy"},        32'(busy),          32'd0);
        checkOutput({tag, " rsp_valid"},   32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, " rsp_data"},    32'(bus.rsp_data),  32'd0);
        checkOutput({tag, " sr_load"},     32'(sr_load),       32'd0);
        checkOutput({tag, " sr_shift_en"}, 32'(sr_shift_en),   32'd0);
    endtask

    // Runs one job from the accept cycle (cycle 0) through the response
    // handshake, holding rsp_ready low for holdCycles result cycles, and
    // leaves the bench one cycle after the handshake.
    task automatic applyStimulus(input logic [7:0] data, input logic [2:0] amt,
                                 input int holdCycles, input string tag);
        logic [7:0] expected;
        int cyc;
        expected      = refShift(int'(data), int'(amt));
        bus.req_valid = 1'b1;
        bus.req_data  = data;
        bus.req_amt   = amt;
        bus.rsp_ready = 1'b0;
        checkOutput({tag, " req_ready@accept"}, 32'(bus.req_ready), 32'd1);
        tick();
        cyc = 1;
        while (bus.rsp_valid !== 1'b1 && cyc < 12) begin
            bus.req_valid = 1'($urandom_range(1, 0));
            bus.req_data  = 8'($urandom);
            bus.req_amt   = 3'($urandom);
            checkOutput({tag, " sr_load"}, 32'(sr_load), 32'(cyc == 1));
            checkOutput({tag, " sr_shift_en"}, 32'(sr_shift_en),
                        32'((cyc >= 2) && (cyc <= int'(amt) + 1)));
            checkOutput({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
            if (cyc == 1) checkOutput({tag, " sr_data_in"}, 32'(sr_data_in), 32'(data));
            tick();
            cyc++;
        end
        checkOutput({tag, " rsp latency"}, 32'(cyc), 32'(int'(amt) + 2));
        for (int h = 0; h < holdCycles; h++) begin
            checkOutput({tag, " rsp_valid hold"}, 32'(bus.rsp_valid), 32'd1);
            checkOutput({tag, " rsp_data hold"},  32'(bus.rsp_data),  32'(expected));
            checkOutput({tag, " req_ready hold"}, 32'(bus.req_ready), 32'd0);
            checkOutput({tag, " sr quiet"}, 32'(sr_load | sr_shift_en), 32'd0);
            bus.req_valid = 1'($urandom_range(1, 0));
            tick();
        end
        checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, " rsp_data"},  32'(bus.rsp_data),  32'(expected));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput({tag, " rsp_valid after"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, " req_ready after"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, " busy after"},      32'(busy),          32'd0);
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.req_amt   = 3'd0;
        bus.rsp_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort         = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        checkIdle("reset");
        checkOutput("reset sr_data_in", 32'(sr_data_in), 32'd0);
        reset = 1'b0;
        checkIdle("post-reset");

        // Directed jobs
        applyStimulus(8'hAA, 3'd3, 0, "tc1");
        applyStimulus(8'hAA, 3'd0, 0, "tc2");
        applyStimulus(8'h01, 3'd7, 5, "tc3");
        applyStimulus(8'hCC, 3'd1, 0, "tc4a");
        applyStimulus(8'h0F, 3'd4, 0, "tc4b");

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            applyStimulus(8'($urandom), 3'($urandom_range(7, 0)),
                          int'($urandom_range(3, 0)), "rnd");
        end

        // Reset in the middle of a shift sequence drops the job
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hFF;
        bus.req_amt   = 3'd6;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("tc5 in shift", 32'(sr_shift_en), 32'd1);
        reset = 1'b1;
        tick();
        checkIdle("tc5 reset");
        checkOutput("tc5 sr_data_in", 32'(sr_data_in), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("tc5 no rsp", 32'(bus.rsp_valid | busy), 32'd0);
            tick();
        end

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the second shift cycle
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hF0;
        bus.req_amt   = 3'd5;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        checkOutput("tc6 in shift", 32'(sr_shift_en), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("tc6 abort_ack", 32'(abort_ack), 32'd1);
        checkIdle("tc6 aborted");
        tick();
        checkOutput("tc6 abort_ack pulse", 32'(abort_ack), 32'd0);
        checkOutput("tc6 no rsp", 32'(bus.rsp_valid), 32'd0);
        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("tc6 idle abort", 32'(abort_ack), 32'd0);
        applyStimulus(8'h03, 3'd1, 0, "tc6 post-abort");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
